// File: rtl/hil_pkg.sv
// hil_pkg: shared definitions for the HIL vector engine and the RPi-side encoder.
//   CMD_CLEAR / CMD_REPORT : command byte codes (bit 7 set marks a command)
//   state_e                : engine FSM states
//   VEC_* / RES_*          : bit positions inside vector and result bytes
//   mk_result              : packs a result byte from its fields
package hil_pkg;

    localparam logic [7:0] CMD_CLEAR  = 8'h80;
    localparam logic [7:0] CMD_REPORT = 8'h81;

    localparam int VEC_CMD_BIT = 7;
    localparam int VEC_EXP_BIT = 6;
    localparam int VEC_S_LSB   = 4;
    localparam int VEC_I_LSB   = 0;

    localparam int RES_MISMATCH_BIT = 7;
    localparam int RES_Y_BIT        = 6;
    localparam int RES_S_LSB        = 4;
    localparam int RES_I_LSB        = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SEND,
        ST_REPORT
    } state_e;

    function automatic logic [7:0] mk_result(input logic mm, input logic y,
                                             input logic [1:0] s, input logic [3:0] i);
        logic [7:0] r;
        r = '0;
        r[RES_MISMATCH_BIT] = mm;
        r[RES_Y_BIT]        = y;
        r[RES_S_LSB +: 2]   = s;
        r[RES_I_LSB +: 4]   = i;
        return r;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, flops clear to 0.
//   clk   : destination clock
//   rst_n : synchronous active-low reset
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles behind d_i
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hil_vector_engine.sv
// hil_vector_engine: applies test vectors to a 4:1 mux DUT and returns pass/fail results.
//   clk, rst_n           : system clock, synchronous active-low reset
//   in_data/valid/ready  : vector and command bytes from the RPi receiver
//   out_data/valid/ready : result and report bytes to the RPi transmitter
//   dut_i, dut_s         : DUT data and select drive, held between vectors
//   dut_y                : asynchronous DUT output
//   pass_cnt, fail_cnt   : saturating match/mismatch counters
//   busy                 : engine is not idle
module hil_vector_engine
    import hil_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       dut_i,
    output logic [1:0]       dut_s,
    input  logic             dut_y,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3 to cover the synchronizer delay");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("CNT_W must be between 1 and 16");
    end

    localparam int SC_W = $clog2(SETTLE_CYCLES);

    state_e           state_q;
    logic [SC_W-1:0]  settle_q;
    logic             exp_q;
    logic [3:0]       dut_i_q;
    logic [1:0]       dut_s_q;
    logic [7:0]       out_data_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic [23:0]      snap_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] pass_d;
    logic [CNT_W-1:0] fail_d;
    logic [7:0]       res_d;
    logic [31:0]      rpt_d;
    logic             y_sync;
    logic             mismatch;

    sync2 #(.W(1)) u_sync_y (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dut_y),
        .q_o   (y_sync)
    );

    always_comb begin
        pass_d   = &pass_q ? pass_q : pass_q + 1'b1;
        fail_d   = &fail_q ? fail_q : fail_q + 1'b1;
        mismatch = y_sync ^ exp_q;
        res_d    = mk_result(mismatch, y_sync, dut_s_q, dut_i_q);
        rpt_d    = {16'(pass_q), 16'(fail_q)};
    end

    // Report bytes after the first are shifted out of snap_q, so the snapshot
    // taken at acceptance is immune to later counter activity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            exp_q       <= 1'b0;
            dut_i_q     <= '0;
            dut_s_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            snap_q      <= '0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!in_data[VEC_CMD_BIT]) begin
                            dut_i_q  <= in_data[VEC_I_LSB +: 4];
                            dut_s_q  <= in_data[VEC_S_LSB +: 2];
                            exp_q    <= in_data[VEC_EXP_BIT];
                            settle_q <= '0;
                            state_q  <= ST_APPLY;
                        end else if (in_data == CMD_CLEAR) begin
                            pass_q <= '0;
                            fail_q <= '0;
                        end else if (in_data == CMD_REPORT) begin
                            out_data_q  <= rpt_d[31:24];
                            snap_q      <= rpt_d[23:0];
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_REPORT;
                        end
                    end
                end
                ST_APPLY: begin
                    if (settle_q == SC_W'(SETTLE_CYCLES - 1)) begin
                        out_data_q  <= res_d;
                        out_valid_q <= 1'b1;
                        if (mismatch) fail_q <= fail_d;
                        else          pass_q <= pass_d;
                        state_q     <= ST_SEND;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_REPORT: begin
                    if (out_ready) begin
                        if (idx_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            out_data_q <= snap_q[23:16];
                            snap_q     <= {snap_q[15:0], 8'h00};
                            idx_q      <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign busy      = state_q != ST_IDLE;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dut_i     = dut_i_q;
    assign dut_s     = dut_s_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;

endmodule
